// File: rtl/instr_sequencer_if.sv
// Purpose: groups the instruction sequencer's request, datapath-control and status signals.
// Latency: none, wires only.
// Backpressure: mem_ready from the memory side stretches FETCH and MEM.
interface instr_sequencer_if #(
    parameter int CNT_W = 32
);
    // Requests and flags from the instruction register, ALU and memory
    logic             start;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             alu_zero;
    logic             mem_ready;

    // Memory and datapath controls
    logic             mem_req;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src;
    logic             mem_to_reg;
    logic             imm_extend;
    logic [2:0]       alu_op;

    // Status
    logic             busy;
    logic             halted;
    logic             fault;
    logic [CNT_W-1:0] retire_cnt;

    // Driver side: instruction source, ALU flag and memory
    modport master (
        output start, opcode, funct, alu_zero, mem_ready,
        input  mem_req, mem_write, ir_write, pc_write, pc_src, reg_write,
               reg_dst, alu_src, mem_to_reg, imm_extend, alu_op,
               busy, halted, fault, retire_cnt
    );

    // Sequencer side
    modport slave (
        input  start, opcode, funct, alu_zero, mem_ready,
        output mem_req, mem_write, ir_write, pc_write, pc_src, reg_write,
               reg_dst, alu_src, mem_to_reg, imm_extend, alu_op,
               busy, halted, fault, retire_cnt
    );
endinterface

// File: rtl/instr_sequencer.sv
// Purpose: multi-cycle control FSM for a small MIPS-like datapath, with retire counter.
// Latency: FETCH to next FETCH is 4 cycles for ALU ops and sw, 5 for lw, 3 for beq.
// Backpressure: FETCH/MEM hold until mem_ready; MEM_TIMEOUT ready-low cycles end in FAULT.
module instr_sequencer #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input logic               clock,
    input logic               clear,
    instr_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // The last permitted ready-low cycle: the wait counter would reach MEM_TIMEOUT on it
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t           state_q;
    state_t           state_nxt;
    logic [5:0]       op_q;
    logic [5:0]       fn_q;
    logic [7:0]       wait_q;
    logic [CNT_W-1:0] retire_q;
    logic             retire_inc;
    logic             timeout;

    // Decoded from the latched instruction fields
    logic [2:0]       dec_alu_op;
    logic             dec_alu_src;
    logic             dec_imm;
    logic             funct_ok;
    logic             is_rtype;
    logic             is_lw;
    logic             is_sw;
    logic             is_beq;

    // Output staging
    logic             mem_req;
    logic             mem_write;
    logic             ir_write;
    logic             pc_write;
    logic             pc_src;
    logic             reg_write;
    logic             reg_dst;
    logic             alu_src;
    logic             mem_to_reg;
    logic             imm_extend;
    logic [2:0]       alu_op;
    logic             busy;
    logic             halted;
    logic             fault;

    // Opcodes accepted at DECODE as executable (halt is handled separately)
    function automatic logic op_known(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_BEQ, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW: op_known = 1'b1;
            default: op_known = 1'b0;
        endcase
    endfunction

    assign is_rtype = (op_q == OP_RTYPE);
    assign is_lw    = (op_q == OP_LW);
    assign is_sw    = (op_q == OP_SW);
    assign is_beq   = (op_q == OP_BEQ);
    assign timeout  = !bus.mem_ready && (wait_q == WAIT_LAST);

    // ALU function, operand select and immediate extension for the latched instruction
    always_comb begin
        dec_alu_op  = ALU_AND;
        dec_alu_src = 1'b0;
        dec_imm     = 1'b0;
        funct_ok    = 1'b0;
        case (op_q)
            OP_RTYPE: begin
                funct_ok = 1'b1;
                case (fn_q)
                    FN_ADD:  dec_alu_op = ALU_ADD;
                    FN_SUB:  dec_alu_op = ALU_SUB;
                    FN_AND:  dec_alu_op = ALU_AND;
                    FN_OR:   dec_alu_op = ALU_OR;
                    FN_SLT:  dec_alu_op = ALU_SLT;
                    default: funct_ok   = 1'b0;
                endcase
            end
            OP_ADDI: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = ALU_ADD;
            end
            OP_SLTI: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = ALU_SLT;
            end
            OP_ANDI: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = ALU_AND;
                dec_imm     = 1'b1;
            end
            OP_ORI: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = ALU_OR;
                dec_imm     = 1'b1;
            end
            OP_LW, OP_SW: begin
                dec_alu_src = 1'b1;
                dec_alu_op  = ALU_ADD;
            end
            OP_BEQ: dec_alu_op = ALU_SUB;
            default: begin
            end
        endcase
    end

    // Next state, datapath controls and retire strobe from state plus latched instruction
    always_comb begin
        state_nxt  = state_q;
        retire_inc = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        imm_extend = 1'b0;
        alu_op     = 3'b000;
        busy       = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                busy    = 1'b1;
                mem_req = 1'b1;
                if (bus.mem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DECODE: begin
                // Fields are being latched this cycle, so route on the live opcode
                busy = 1'b1;
                if (bus.opcode == OP_HALT)     state_nxt = S_HALT;
                else if (op_known(bus.opcode)) state_nxt = S_EXEC;
                else                           state_nxt = S_FAULT;
            end
            S_EXEC: begin
                busy       = 1'b1;
                alu_op     = dec_alu_op;
                alu_src    = dec_alu_src;
                imm_extend = dec_imm;
                if (is_rtype && !funct_ok) begin
                    state_nxt = S_FAULT;
                end else if (is_lw || is_sw) begin
                    state_nxt = S_MEM;
                end else if (is_beq) begin
                    pc_write   = bus.alu_zero;
                    pc_src     = bus.alu_zero;
                    retire_inc = 1'b1;
                    state_nxt  = S_FETCH;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_MEM: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_write = is_sw;
                if (bus.mem_ready) begin
                    retire_inc = is_sw;
                    state_nxt  = is_sw ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end
            end
            S_WB: begin
                // ALU controls stay as in EXEC so the written result is unchanged;
                // zero-extension belongs to the ALU operand and is kept with them
                busy       = 1'b1;
                reg_write  = 1'b1;
                reg_dst    = is_rtype;
                mem_to_reg = is_lw;
                alu_op     = dec_alu_op;
                alu_src    = dec_alu_src;
                imm_extend = dec_imm;
                retire_inc = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register; clear wins over every transition
    always_ff @(posedge clock) begin
        if (clear) state_q <= S_IDLE;
        else       state_q <= state_nxt;
    end

    // Capture the instruction fields once, in DECODE
    always_ff @(posedge clock) begin
        if (clear) begin
            op_q <= 6'h00;
            fn_q <= 6'h00;
        end else if (state_q == S_DECODE) begin
            op_q <= bus.opcode;
            fn_q <= bus.funct;
        end
    end

    // Memory wait counter: zeroed on any state change, counts ready-low cycles in FETCH/MEM
    always_ff @(posedge clock) begin
        if (clear) begin
            wait_q <= 8'd0;
        end else if (state_nxt != state_q) begin
            wait_q <= 8'd0;
        end else if ((state_q == S_FETCH || state_q == S_MEM) && !bus.mem_ready) begin
            wait_q <= wait_q + 8'd1;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clock) begin
        if (clear)           retire_q <= '0;
        else if (retire_inc) retire_q <= retire_q + CNT_W'(1);
    end

    assign bus.mem_req    = mem_req;
    assign bus.mem_write  = mem_write;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.pc_src     = pc_src;
    assign bus.reg_write  = reg_write;
    assign bus.reg_dst    = reg_dst;
    assign bus.alu_src    = alu_src;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.imm_extend = imm_extend;
    assign bus.alu_op     = alu_op;
    assign bus.busy       = busy;
    assign bus.halted     = halted;
    assign bus.fault      = fault;
    assign bus.retire_cnt = retire_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Purpose: directed, table-driven check of instr_sequencer controls, status and retire count.
// Latency: one table row per clock; inputs driven after the rising edge, outputs sampled on the falling edge.
// Backpressure: mem_ready is driven low in rows to stretch FETCH/MEM and to force timeouts.
module tb_instr_sequencer;

    localparam logic [15:0] B_MREQ = 16'h8000;
    localparam logic [15:0] B_MWR  = 16'h4000;
    localparam logic [15:0] B_IRW  = 16'h2000;
    localparam logic [15:0] B_PCW  = 16'h1000;
    localparam logic [15:0] B_PCS  = 16'h0800;
    localparam logic [15:0] B_RW   = 16'h0400;
    localparam logic [15:0] B_RD   = 16'h0200;
    localparam logic [15:0] B_AS   = 16'h0100;
    localparam logic [15:0] B_M2R  = 16'h0080;
    localparam logic [15:0] B_IMM  = 16'h0040;
    localparam logic [15:0] A_ADD  = 16'h0010;
    localparam logic [15:0] A_SUB  = 16'h0030;
    localparam logic [15:0] A_AND  = 16'h0000;
    localparam logic [15:0] A_OR   = 16'h0008;
    localparam logic [15:0] A_SLT  = 16'h0038;
    localparam logic [15:0] B_BUSY = 16'h0004;
    localparam logic [15:0] B_HALT = 16'h0002;
    localparam logic [15:0] B_FLT  = 16'h0001;

    localparam logic [15:0] P_FR = B_MREQ | B_IRW | B_PCW | B_BUSY;
    localparam logic [15:0] P_FW = B_MREQ | B_BUSY;

    typedef struct {
        string       nm;
        logic        cl;
        logic        st;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        z;
        logic        rd;
        logic [15:0] ex;
        logic [3:0]  cn;
    } vec_t;

    logic clock;
    logic clear;
    int   errors;
    int   checks;
    vec_t tbl[$];

    instr_sequencer_if #(.CNT_W(4)) bus ();

    instr_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] outs();
        return {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.reg_write, bus.reg_dst, bus.alu_src, bus.mem_to_reg, bus.imm_extend,
                bus.alu_op, bus.busy, bus.halted, bus.fault};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input string nm, input logic cl, input logic st, input logic [5:0] op,
                       input logic [5:0] fn, input logic z, input logic rd,
                       input logic [15:0] ex, input logic [3:0] cn);
        vec_t v;
        v.nm = nm; v.cl = cl; v.st = st; v.op = op; v.fn = fn;
        v.z = z; v.rd = rd; v.ex = ex; v.cn = cn;
        tbl.push_back(v);
    endtask

    // FETCH/DECODE/EXEC/WB rows of a zero-wait ALU instruction; start in DECODE must be ignored
    task automatic alu_instr(input string nm, input logic [5:0] op, input logic [5:0] fn,
                             input logic [15:0] ex_exec, input logic [15:0] ex_wb, input logic [3:0] cn);
        add({nm, "_fetch"}, 0, 0, op, fn, 0, 1, P_FR,    cn);
        add({nm, "_dec"},   0, 1, op, fn, 0, 1, B_BUSY,  cn);
        add({nm, "_exec"},  0, 0, op, fn, 0, 1, ex_exec, cn);
        add({nm, "_wb"},    0, 0, op, fn, 0, 1, ex_wb,   cn);
    endtask

    task automatic beq_instr(input string nm, input logic z, input logic [15:0] ex_exec, input logic [3:0] cn);
        add({nm, "_fetch"}, 0, 0, 6'h04, 6'h00, z, 1, P_FR,    cn);
        add({nm, "_dec"},   0, 0, 6'h04, 6'h00, z, 1, B_BUSY,  cn);
        add({nm, "_exec"},  0, 0, 6'h04, 6'h00, z, 1, ex_exec, cn);
    endtask

    task automatic step(input logic cl, input logic st, input logic [5:0] op, input logic [5:0] fn,
                        input logic z, input logic rd);
        @(posedge clock);
        #1;
        clear         = cl;
        bus.start     = st;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.alu_zero  = z;
        bus.mem_ready = rd;
        @(negedge clock);
    endtask

    initial begin
        int  n;
        logic seen;
        errors = 0;
        checks = 0;
        clear = 1'b1;
        bus.start = 1'b0; bus.opcode = 6'h00; bus.funct = 6'h00;
        bus.alu_zero = 1'b0; bus.mem_ready = 1'b0;
        repeat (2) @(posedge clock);

        // Reset state, then a 16-instruction program that wraps the 4-bit retire counter
        add("idle",       0, 0, 6'h00, 6'h00, 0, 0, 16'h0000, 4'd0);
        add("idle_start", 0, 1, 6'h00, 6'h20, 0, 1, 16'h0000, 4'd0);
        alu_instr("add",  6'h00, 6'h20, B_BUSY | A_ADD,         B_BUSY | B_RW | B_RD | A_ADD,          4'd0);
        alu_instr("sub",  6'h00, 6'h22, B_BUSY | A_SUB,         B_BUSY | B_RW | B_RD | A_SUB,          4'd1);
        alu_instr("and",  6'h00, 6'h24, B_BUSY | A_AND,         B_BUSY | B_RW | B_RD | A_AND,          4'd2);
        alu_instr("or",   6'h00, 6'h25, B_BUSY | A_OR,          B_BUSY | B_RW | B_RD | A_OR,           4'd3);
        alu_instr("slt",  6'h00, 6'h2A, B_BUSY | A_SLT,         B_BUSY | B_RW | B_RD | A_SLT,          4'd4);
        alu_instr("addi", 6'h08, 6'h00, B_BUSY | B_AS | A_ADD,  B_BUSY | B_RW | B_AS | A_ADD,          4'd5);
        alu_instr("slti", 6'h0A, 6'h00, B_BUSY | B_AS | A_SLT,  B_BUSY | B_RW | B_AS | A_SLT,          4'd6);
        alu_instr("andi", 6'h0C, 6'h00, B_BUSY | B_AS | B_IMM | A_AND, B_BUSY | B_RW | B_AS | B_IMM | A_AND, 4'd7);
        // ori with the opcode input switched to sw after DECODE: latched fields must rule
        add("ori_fetch", 0, 0, 6'h0D, 6'h00, 0, 1, P_FR,   4'd8);
        add("ori_dec",   0, 0, 6'h0D, 6'h00, 0, 1, B_BUSY, 4'd8);
        add("ori_exec",  0, 0, 6'h2B, 6'h20, 0, 1, B_BUSY | B_AS | B_IMM | A_OR,        4'd8);
        add("ori_wb",    0, 0, 6'h2B, 6'h20, 0, 1, B_BUSY | B_RW | B_AS | B_IMM | A_OR, 4'd8);
        // lw with three ready-low cycles in MEM
        add("lw_fetch",  0, 0, 6'h23, 6'h00, 0, 1, P_FR,                  4'd9);
        add("lw_dec",    0, 0, 6'h23, 6'h00, 0, 1, B_BUSY,                4'd9);
        add("lw_exec",   0, 0, 6'h23, 6'h00, 0, 1, B_BUSY | B_AS | A_ADD, 4'd9);
        repeat (3) add("lw_mem_wait", 0, 0, 6'h23, 6'h00, 0, 0, P_FW,     4'd9);
        add("lw_mem_rdy", 0, 0, 6'h23, 6'h00, 0, 1, P_FW,                 4'd9);
        add("lw_wb",     0, 0, 6'h23, 6'h00, 0, 1, B_BUSY | B_RW | B_AS | A_ADD | B_M2R, 4'd9);
        add("sw_fetch",  0, 0, 6'h2B, 6'h00, 0, 1, P_FR,                  4'd10);
        add("sw_dec",    0, 0, 6'h2B, 6'h00, 0, 1, B_BUSY,                4'd10);
        add("sw_exec",   0, 0, 6'h2B, 6'h00, 0, 1, B_BUSY | B_AS | A_ADD, 4'd10);
        add("sw_mem",    0, 0, 6'h2B, 6'h00, 0, 1, B_MREQ | B_MWR | B_BUSY, 4'd10);
        beq_instr("beq_t", 1, B_BUSY | A_SUB | B_PCW | B_PCS, 4'd11);
        beq_instr("beq_n", 0, B_BUSY | A_SUB,                 4'd12);
        repeat (2) add("addi2_fwait", 0, 0, 6'h08, 6'h00, 0, 0, P_FW, 4'd13);
        alu_instr("addi2", 6'h08, 6'h00, B_BUSY | B_AS | A_ADD, B_BUSY | B_RW | B_AS | A_ADD, 4'd13);
        beq_instr("beq_14", 0, B_BUSY | A_SUB,                 4'd14);
        beq_instr("beq_15", 1, B_BUSY | A_SUB | B_PCW | B_PCS, 4'd15);
        // Wrapped counter, then an R-type with an unknown funct faults without retiring
        add("badfn_fetch", 0, 0, 6'h00, 6'h3F, 0, 1, P_FR,   4'd0);
        add("badfn_dec",   0, 0, 6'h00, 6'h3F, 0, 1, B_BUSY, 4'd0);
        add("badfn_exec",  0, 0, 6'h00, 6'h3F, 0, 1, B_BUSY, 4'd0);
        add("badfn_fault", 0, 1, 6'h00, 6'h3F, 0, 1, B_FLT,  4'd0);
        add("badfn_stick", 0, 0, 6'h00, 6'h3F, 0, 1, B_FLT,  4'd0);
        add("badfn_clr",   1, 0, 6'h00, 6'h3F, 0, 1, B_FLT,  4'd0);
        add("badfn_idle",  0, 0, 6'h00, 6'h00, 0, 0, 16'h0000, 4'd0);
        // Unknown opcode faults from DECODE
        add("badop_start", 0, 1, 6'h02, 6'h00, 0, 1, 16'h0000, 4'd0);
        add("badop_fetch", 0, 0, 6'h02, 6'h00, 0, 1, P_FR,   4'd0);
        add("badop_dec",   0, 0, 6'h02, 6'h00, 0, 1, B_BUSY, 4'd0);
        add("badop_fault", 0, 1, 6'h02, 6'h00, 0, 1, B_FLT,  4'd0);
        add("badop_clr",   1, 0, 6'h02, 6'h00, 0, 1, B_FLT,  4'd0);
        add("badop_idle",  0, 0, 6'h00, 6'h00, 0, 0, 16'h0000, 4'd0);
        // Halt is sticky and ignores start
        add("halt_start",  0, 1, 6'h3F, 6'h00, 0, 1, 16'h0000, 4'd0);
        add("halt_fetch",  0, 0, 6'h3F, 6'h00, 0, 1, P_FR,   4'd0);
        add("halt_dec",    0, 0, 6'h3F, 6'h00, 0, 1, B_BUSY, 4'd0);
        add("halt_state",  0, 1, 6'h3F, 6'h00, 0, 1, B_HALT, 4'd0);
        add("halt_stick",  0, 1, 6'h3F, 6'h00, 0, 1, B_HALT, 4'd0);
        add("halt_clr",    1, 0, 6'h3F, 6'h00, 0, 1, B_HALT, 4'd0);
        add("halt_idle",   0, 0, 6'h00, 6'h00, 0, 0, 16'h0000, 4'd0);
        // Ready arriving on the last permitted wait cycle completes normally (FETCH and MEM)
        add("edge_start",  0, 1, 6'h2B, 6'h00, 0, 0, 16'h0000, 4'd0);
        repeat (14) add("edge_fwait", 0, 0, 6'h2B, 6'h00, 0, 0, P_FW, 4'd0);
        add("edge_frdy",   0, 0, 6'h2B, 6'h00, 0, 1, P_FR,   4'd0);
        add("edge_dec",    0, 0, 6'h2B, 6'h00, 0, 1, B_BUSY, 4'd0);
        add("edge_exec",   0, 0, 6'h2B, 6'h00, 0, 0, B_BUSY | B_AS | A_ADD, 4'd0);
        repeat (14) add("edge_mwait", 0, 0, 6'h2B, 6'h00, 0, 0, B_MREQ | B_MWR | B_BUSY, 4'd0);
        add("edge_mrdy",   0, 0, 6'h2B, 6'h00, 0, 1, B_MREQ | B_MWR | B_BUSY, 4'd0);
        // Clear in the MEM cycle of a sw aborts it without retiring
        add("swclr_fetch", 0, 0, 6'h2B, 6'h00, 0, 1, P_FR,   4'd1);
        add("swclr_dec",   0, 0, 6'h2B, 6'h00, 0, 1, B_BUSY, 4'd1);
        add("swclr_exec",  0, 0, 6'h2B, 6'h00, 0, 0, B_BUSY | B_AS | A_ADD, 4'd1);
        add("swclr_mem",   1, 0, 6'h2B, 6'h00, 0, 0, B_MREQ | B_MWR | B_BUSY, 4'd1);
        add("swclr_idle",  0, 0, 6'h2B, 6'h00, 0, 0, 16'h0000, 4'd0);
        // lw timing out in MEM
        add("mto_start",   0, 1, 6'h23, 6'h00, 0, 1, 16'h0000, 4'd0);
        add("mto_fetch",   0, 0, 6'h23, 6'h00, 0, 1, P_FR,   4'd0);
        add("mto_dec",     0, 0, 6'h23, 6'h00, 0, 1, B_BUSY, 4'd0);
        add("mto_exec",    0, 0, 6'h23, 6'h00, 0, 0, B_BUSY | B_AS | A_ADD, 4'd0);
        repeat (15) add("mto_mwait", 0, 0, 6'h23, 6'h00, 0, 0, P_FW, 4'd0);
        add("mto_fault",   0, 1, 6'h23, 6'h00, 0, 1, B_FLT,  4'd0);
        add("mto_clr",     1, 0, 6'h23, 6'h00, 0, 1, B_FLT,  4'd0);
        add("mto_idle",    0, 0, 6'h00, 6'h00, 0, 0, 16'h0000, 4'd0);

        foreach (tbl[i]) begin
            step(tbl[i].cl, tbl[i].st, tbl[i].op, tbl[i].fn, tbl[i].z, tbl[i].rd);
            chk({tbl[i].nm, "_ctl"}, 32'(outs()), 32'(tbl[i].ex));
            chk({tbl[i].nm, "_cnt"}, 32'(bus.retire_cnt), 32'(tbl[i].cn));
        end

        // FETCH timeout after one retired beq: count wait cycles up to the fault, bounded
        step(1, 0, 6'h00, 6'h00, 0, 0);
        step(0, 1, 6'h04, 6'h00, 1, 1);
        chk("to_idle", 32'(outs()), 32'h0);
        step(0, 0, 6'h04, 6'h00, 1, 1);
        chk("to_fetch", 32'(outs()), 32'(P_FR));
        step(0, 0, 6'h04, 6'h00, 1, 1);
        step(0, 0, 6'h04, 6'h00, 1, 1);
        chk("to_beq_exec", 32'(outs()), 32'(B_BUSY | A_SUB | B_PCW | B_PCS));
        n = 0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            step(0, 0, 6'h04, 6'h00, 1, 0);
            if (bus.fault) begin
                seen = 1'b1;
                break;
            end
            if (bus.mem_req) n++;
        end
        chk("to_fault_seen", 32'(seen), 32'd1);
        chk("to_wait_cycles", 32'(n), 32'd15);
        chk("to_retire", 32'(bus.retire_cnt), 32'd1);
        step(0, 1, 6'h04, 6'h00, 1, 1);
        chk("to_sticky", 32'(outs()), 32'(B_FLT));
        chk("to_sticky_cnt", 32'(bus.retire_cnt), 32'd1);
        step(1, 0, 6'h00, 6'h00, 0, 0);
        step(0, 0, 6'h00, 6'h00, 0, 0);
        chk("to_cleared", 32'(outs()), 32'h0);
        chk("to_cleared_cnt", 32'(bus.retire_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
